// File: rtl/decode_forward_stage_pkg.sv
// Shared Y86 constants, D/E register record and counter helper for the decode/forward stage.
package decode_forward_stage_pkg;

    localparam int DATA_WID = 64;
    localparam int ADDR_WID = 4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [ADDR_WID-1:0] RNONE = 4'hF;
    localparam logic [ADDR_WID-1:0] RSP   = 4'h4;

    typedef struct packed {
        logic [3:0]          icode;
        logic [3:0]          ifun;
        logic [DATA_WID-1:0] valC;
        logic [DATA_WID-1:0] valA;
        logic [DATA_WID-1:0] valB;
        logic [ADDR_WID-1:0] dstE;
        logic [ADDR_WID-1:0] dstM;
        logic [ADDR_WID-1:0] srcA;
        logic [ADDR_WID-1:0] srcB;
    } deReg_t;

    function automatic deReg_t nopReg();
        deReg_t r;
        r       = '0;
        r.icode = I_NOP;
        r.dstE  = RNONE;
        r.dstM  = RNONE;
        r.srcA  = RNONE;
        r.srcB  = RNONE;
        return r;
    endfunction

    function automatic logic [31:0] satAdd(input logic [31:0] cnt, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, cnt} + {31'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/decode_fwd_mux.sv
// Priority operand forwarding: valP leg (optional), then E, M(load), M(alu), W(load), W(alu), else regfile.
// Purely combinational, no backpressure; fwdHit flags a value taken from a pipeline forward leg.
module decode_fwd_mux
    import decode_forward_stage_pkg::*;
#(
    parameter int DW       = DATA_WID,
    parameter int AW       = ADDR_WID,
    parameter bit USE_VALP = 1'b0
) (
    input  logic [3:0]    icode,
    input  logic [DW-1:0] valP,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] eDstE,
    input  logic [DW-1:0] eValE,
    input  logic [AW-1:0] mDstM,
    input  logic [DW-1:0] mValM,
    input  logic [AW-1:0] mDstE,
    input  logic [DW-1:0] mValE,
    input  logic [AW-1:0] wDstM,
    input  logic [DW-1:0] wValM,
    input  logic [AW-1:0] wDstE,
    input  logic [DW-1:0] wValE,
    input  logic [DW-1:0] regVal,
    output logic [DW-1:0] fwdVal,
    output logic          fwdHit
);

    localparam logic [AW-1:0] NONE_ID = {AW{1'b1}};

    logic takeValP;
    assign takeValP = USE_VALP && ((icode == I_CALL) || (icode == I_JXX));

    always_comb begin
        fwdVal = regVal;
        fwdHit = 1'b0;
        if (takeValP) begin
            fwdVal = valP;
        end else if (src != NONE_ID) begin
            // Order matters: the youngest in-flight producer must win.
            if (src == eDstE) begin
                fwdVal = eValE;
                fwdHit = 1'b1;
            end else if (src == mDstM) begin
                fwdVal = mValM;
                fwdHit = 1'b1;
            end else if (src == mDstE) begin
                fwdVal = mValE;
                fwdHit = 1'b1;
            end else if (src == wDstM) begin
                fwdVal = wValM;
                fwdHit = 1'b1;
            end else if (src == wDstE) begin
                fwdVal = wValE;
                fwdHit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_forward_stage.sv
// Y86 decode + forwarding into the D/E register; 1-cycle latency; E_stall holds, E_bubble injects NOP.
// Define DECODE_FWD_CNT_EN to build the saturating forwarded-operand counter on fwd_cnt.
module decode_forward_stage
    import decode_forward_stage_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    input  logic [3:0]          D_icode,
    input  logic [3:0]          D_ifun,
    input  logic [ADDR_WID-1:0] D_rA,
    input  logic [ADDR_WID-1:0] D_rB,
    input  logic [DATA_WID-1:0] D_valC,
    input  logic [DATA_WID-1:0] D_valP,
    output logic [ADDR_WID-1:0] srcA,
    output logic [ADDR_WID-1:0] srcB,
    input  logic [DATA_WID-1:0] valA,
    input  logic [DATA_WID-1:0] valB,
    input  logic [ADDR_WID-1:0] e_dstE,
    input  logic [DATA_WID-1:0] e_valE,
    input  logic [ADDR_WID-1:0] M_dstE,
    input  logic [DATA_WID-1:0] M_valE,
    input  logic [ADDR_WID-1:0] M_dstM,
    input  logic [DATA_WID-1:0] m_valM,
    input  logic [ADDR_WID-1:0] W_dstE,
    input  logic [DATA_WID-1:0] W_valE,
    input  logic [ADDR_WID-1:0] W_dstM,
    input  logic [DATA_WID-1:0] W_valM,
    input  logic                E_stall,
    input  logic                E_bubble,
    output logic [3:0]          E_icode,
    output logic [3:0]          E_ifun,
    output logic [DATA_WID-1:0] E_valC,
    output logic [DATA_WID-1:0] E_valA,
    output logic [DATA_WID-1:0] E_valB,
    output logic [ADDR_WID-1:0] E_dstE,
    output logic [ADDR_WID-1:0] E_dstM,
    output logic [ADDR_WID-1:0] E_srcA,
    output logic [ADDR_WID-1:0] E_srcB,
    output logic                load_use,
    output logic [31:0]         fwd_cnt
);

    logic [ADDR_WID-1:0] dstE;
    logic [ADDR_WID-1:0] dstM;
    logic [DATA_WID-1:0] dValA;
    logic [DATA_WID-1:0] dValB;
    logic                hitA;
    logic                hitB;
    logic                loadEn;
    deReg_t              dNext;
    deReg_t              eReg;

    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (D_icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srcA = D_rA;
            I_POPQ, I_RET:                      srcA = RSP;
            default:                            ;
        endcase
        case (D_icode)
            I_OPQ, I_RMMOVQ, I_MRMOVQ:          srcB = D_rB;
            I_PUSHQ, I_POPQ, I_CALL, I_RET:     srcB = RSP;
            default:                            ;
        endcase
        case (D_icode)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:          dstE = D_rB;
            I_PUSHQ, I_POPQ, I_CALL, I_RET:     dstE = RSP;
            default:                            ;
        endcase
        case (D_icode)
            I_MRMOVQ, I_POPQ:                   dstM = D_rA;
            default:                            ;
        endcase
    end

    decode_fwd_mux #(
        .DW       (DATA_WID),
        .AW       (ADDR_WID),
        .USE_VALP (1'b1)
    ) u_fwdA (
        .icode  (D_icode),
        .valP   (D_valP),
        .src    (srcA),
        .eDstE  (e_dstE),
        .eValE  (e_valE),
        .mDstM  (M_dstM),
        .mValM  (m_valM),
        .mDstE  (M_dstE),
        .mValE  (M_valE),
        .wDstM  (W_dstM),
        .wValM  (W_valM),
        .wDstE  (W_dstE),
        .wValE  (W_valE),
        .regVal (valA),
        .fwdVal (dValA),
        .fwdHit (hitA)
    );

    decode_fwd_mux #(
        .DW       (DATA_WID),
        .AW       (ADDR_WID),
        .USE_VALP (1'b0)
    ) u_fwdB (
        .icode  (D_icode),
        .valP   (D_valP),
        .src    (srcB),
        .eDstE  (e_dstE),
        .eValE  (e_valE),
        .mDstM  (M_dstM),
        .mValM  (m_valM),
        .mDstE  (M_dstE),
        .mValE  (M_valE),
        .wDstM  (W_dstM),
        .wValM  (W_valM),
        .wDstE  (W_dstE),
        .wValE  (W_valE),
        .regVal (valB),
        .fwdVal (dValB),
        .fwdHit (hitB)
    );

    always_comb begin
        dNext       = '0;
        dNext.icode = D_icode;
        dNext.ifun  = D_ifun;
        dNext.valC  = D_valC;
        dNext.valA  = dValA;
        dNext.valB  = dValB;
        dNext.dstE  = dstE;
        dNext.dstM  = dstM;
        dNext.srcA  = srcA;
        dNext.srcB  = srcB;
    end

    assign loadEn = !E_bubble && !E_stall;

    // Bubble outranks stall so hazard control can squash a held instruction.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            eReg <= nopReg();
        end else if (E_bubble) begin
            eReg <= nopReg();
        end else if (!E_stall) begin
            eReg <= dNext;
        end
    end

    assign E_icode = eReg.icode;
    assign E_ifun  = eReg.ifun;
    assign E_valC  = eReg.valC;
    assign E_valA  = eReg.valA;
    assign E_valB  = eReg.valB;
    assign E_dstE  = eReg.dstE;
    assign E_dstM  = eReg.dstM;
    assign E_srcA  = eReg.srcA;
    assign E_srcB  = eReg.srcB;

    assign load_use = ((eReg.icode == I_MRMOVQ) || (eReg.icode == I_POPQ))
                      && (eReg.dstM != RNONE)
                      && ((eReg.dstM == srcA) || (eReg.dstM == srcB));

`ifdef DECODE_FWD_CNT_EN
    logic [31:0] fwdCnt;
    logic [1:0]  hitCnt;

    assign hitCnt = {1'b0, hitA} + {1'b0, hitB};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fwdCnt <= '0;
        end else if (loadEn) begin
            fwdCnt <= satAdd(fwdCnt, hitCnt);
        end
    end

    assign fwd_cnt = fwdCnt;
`else
    logic unusedFwd;
    assign unusedFwd = ^{hitA, hitB, loadEn};
    assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_decode_forward_stage.sv
// Self-checking bench for decode_forward_stage: vector table through a scoreboard plus stall/bubble/reset sequences.
module tb_decode_forward_stage;
    import decode_forward_stage_pkg::*;

`ifdef DECODE_FWD_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [63:0] RF_A  = 64'h99;
    localparam logic [63:0] RF_B  = 64'h98;
    localparam logic [63:0] VALP  = 64'h40;
    localparam logic [63:0] EVALE = 64'h11;
    localparam logic [63:0] MVALM = 64'hAA;
    localparam logic [63:0] MVALE = 64'h33;
    localparam logic [63:0] WVALM = 64'h44;
    localparam logic [63:0] WVALE = 64'h22;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP, valA, valB;
    logic [3:0]  srcA, srcB;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic        E_stall, E_bubble;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;
    logic        load_use;
    logic [31:0] fwd_cnt;

    always #5 CLK = ~CLK;

    decode_forward_stage dut (
        .CLK(CLK), .RST(RST),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .E_stall(E_stall), .E_bubble(E_bubble),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .load_use(load_use), .fwd_cnt(fwd_cnt)
    );

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } eRec_t;

    typedef struct {
        logic [3:0]  icode, rA, rB;
        logic [3:0]  eD, mDM, mDE, wDM, wDE;
        logic [3:0]  xSrcA, xSrcB, xDstE, xDstM;
        logic [63:0] xValA, xValB;
        int          xHits;
    } vec_t;

    typedef struct {
        eRec_t e;
        int    hits;
    } sbEnt_t;

    vec_t        vecs[11];
    sbEnt_t      sbq[$];
    int          passCnt  = 0;
    int          checkCnt = 0;
    logic [31:0] expFwd   = 0;
    eRec_t       nopRec, heldE;

    function automatic vec_t mk(input logic [3:0] icode, rA, rB, eD, mDM, mDE, wDM, wDE,
                                input logic [3:0] xSrcA, xSrcB, xDstE, xDstM,
                                input logic [63:0] xValA, xValB, input int xHits);
        vec_t v;
        v.icode = icode; v.rA = rA; v.rB = rB;
        v.eD = eD; v.mDM = mDM; v.mDE = mDE; v.wDM = wDM; v.wDE = wDE;
        v.xSrcA = xSrcA; v.xSrcB = xSrcB; v.xDstE = xDstE; v.xDstM = xDstM;
        v.xValA = xValA; v.xValB = xValB; v.xHits = xHits;
        return v;
    endfunction

    function automatic eRec_t getE();
        return {E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB};
    endfunction

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checkCnt++;
        if (got === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic setD(input logic [3:0] icode, ifun, rA, rB, input logic [63:0] valC);
        D_icode = icode; D_ifun = ifun; D_rA = rA; D_rB = rB; D_valC = valC;
    endtask

    task automatic setFwd(input logic [3:0] eD, mDM, mDE, wDM, wDE);
        e_dstE = eD; M_dstM = mDM; M_dstE = mDE; W_dstM = wDM; W_dstE = wDE;
    endtask

    task automatic popCheck(input string name);
        sbEnt_t s;
        if (sbq.size() == 0) begin
            chk({name, " sb_empty"}, 256'(1), 256'(0));
        end else begin
            s = sbq.pop_front();
            if (CNT_EN) expFwd = expFwd + 32'(s.hits);
            chk({name, " E"}, 256'(getE()), 256'(s.e));
            chk({name, " fwd_cnt"}, 256'(fwd_cnt), 256'(expFwd));
        end
    endtask

    initial begin
        nopRec = '{icode: 4'h1, ifun: 4'h0, valC: 64'h0, valA: 64'h0, valB: 64'h0,
                   dstE: 4'hF, dstM: 4'hF, srcA: 4'hF, srcB: 4'hF};

        //            icode     rA    rB    eD    mDM   mDE   wDM   wDE   xSrcA xSrcB xDstE xDstM xValA  xValB  hits
        vecs[0]  = mk(I_OPQ,    4'h2, 4'h3, 4'h2, 4'hF, 4'hF, 4'hF, 4'h3, 4'h2, 4'h3, 4'h3, 4'hF, EVALE, WVALE, 2);
        vecs[1]  = mk(I_OPQ,    4'h5, 4'h7, 4'hF, 4'h5, 4'hF, 4'hF, 4'h5, 4'h5, 4'h7, 4'h7, 4'hF, MVALM, RF_B,  1);
        vecs[2]  = mk(I_CALL,   4'hF, 4'hF, 4'h4, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h4, 4'h4, 4'hF, VALP,  EVALE, 1);
        vecs[3]  = mk(I_RRMOVQ, 4'h1, 4'h2, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h1, 4'hF, 4'h2, 4'hF, RF_A,  RF_B,  0);
        vecs[4]  = mk(I_MRMOVQ, 4'h6, 4'h3, 4'hF, 4'hF, 4'h3, 4'hF, 4'hF, 4'hF, 4'h3, 4'hF, 4'h6, RF_A,  MVALE, 1);
        vecs[5]  = mk(I_POPQ,   4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'h4, 4'hF, 4'h4, 4'h4, 4'h4, 4'h7, WVALM, WVALM, 2);
        vecs[6]  = mk(I_PUSHQ,  4'h8, 4'hF, 4'hF, 4'hF, 4'hF, 4'h4, 4'h8, 4'h8, 4'h4, 4'h4, 4'hF, WVALE, WVALM, 2);
        vecs[7]  = mk(I_JXX,    4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, VALP,  RF_B,  0);
        vecs[8]  = mk(I_IRMOVQ, 4'hF, 4'h9, 4'h9, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h9, 4'hF, RF_A,  RF_B,  0);
        vecs[9]  = mk(I_RET,    4'hF, 4'hF, 4'h4, 4'h4, 4'hF, 4'hF, 4'hF, 4'h4, 4'h4, 4'h4, 4'hF, EVALE, EVALE, 2);
        vecs[10] = mk(I_RMMOVQ, 4'h1, 4'h2, 4'hF, 4'h2, 4'h1, 4'h1, 4'hF, 4'h1, 4'h2, 4'hF, 4'hF, MVALE, MVALM, 2);

        RST = 1'b1; E_stall = 1'b0; E_bubble = 1'b0;
        setD(I_NOP, 4'h0, 4'hF, 4'hF, 64'h0);
        setFwd(4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        D_valP = VALP; valA = RF_A; valB = RF_B;
        e_valE = EVALE; m_valM = MVALM; M_valE = MVALE; W_valM = WVALM; W_valE = WVALE;

        #3;
        chk("reset E", 256'(getE()), 256'(nopRec));
        chk("reset load_use", 256'(load_use), 256'(0));
        chk("reset fwd_cnt", 256'(fwd_cnt), 256'(0));
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 11; i++) begin
            sbEnt_t s;
            @(negedge CLK);
            setD(vecs[i].icode, 4'(i), vecs[i].rA, vecs[i].rB, 64'h1000 + 64'(i));
            setFwd(vecs[i].eD, vecs[i].mDM, vecs[i].mDE, vecs[i].wDM, vecs[i].wDE);
            s.e = '{icode: vecs[i].icode, ifun: 4'(i), valC: 64'h1000 + 64'(i),
                    valA: vecs[i].xValA, valB: vecs[i].xValB,
                    dstE: vecs[i].xDstE, dstM: vecs[i].xDstM,
                    srcA: vecs[i].xSrcA, srcB: vecs[i].xSrcB};
            s.hits = vecs[i].xHits;
            sbq.push_back(s);
            #2;
            chk($sformatf("vec%0d srcA/srcB", i), 256'({srcA, srcB}), 256'({vecs[i].xSrcA, vecs[i].xSrcB}));
            @(posedge CLK);
            #1;
            popCheck($sformatf("vec%0d", i));
        end

        // Load-use hazard, then stall holds E, then bubble+stall squashes it.
        @(negedge CLK);
        setD(I_MRMOVQ, 4'h0, 4'h6, 4'h3, 64'h55);
        setFwd(4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        heldE = '{icode: I_MRMOVQ, ifun: 4'h0, valC: 64'h55, valA: RF_A, valB: RF_B,
                  dstE: 4'hF, dstM: 4'h6, srcA: 4'hF, srcB: 4'h3};
        @(posedge CLK);
        #1;
        chk("mrmovq in E", 256'(getE()), 256'(heldE));

        @(negedge CLK);
        setD(I_OPQ, 4'h0, 4'h6, 4'h1, 64'h66);
        setFwd(4'h6, 4'hF, 4'hF, 4'hF, 4'hF);
        #2;
        chk("load_use on srcA", 256'(load_use), 256'(1));
        E_stall = 1'b1;
        @(posedge CLK);
        #1;
        chk("stall holds E", 256'(getE()), 256'(heldE));
        chk("stall fwd_cnt", 256'(fwd_cnt), 256'(expFwd));

        @(negedge CLK);
        setD(I_OPQ, 4'h0, 4'h1, 4'h6, 64'h77);
        #2;
        chk("load_use on srcB", 256'(load_use), 256'(1));
        setD(I_OPQ, 4'h0, 4'h1, 4'h2, 64'h77);
        #1;
        chk("load_use no match", 256'(load_use), 256'(0));
        setD(I_OPQ, 4'h0, 4'h6, 4'h1, 64'h66);
        E_bubble = 1'b1;
        @(posedge CLK);
        #1;
        chk("bubble beats stall", 256'(getE()), 256'(nopRec));
        chk("bubble fwd_cnt", 256'(fwd_cnt), 256'(expFwd));
        chk("load_use after bubble", 256'(load_use), 256'(0));

        // Asynchronous reset in the middle of a load.
        @(negedge CLK);
        E_stall = 1'b0; E_bubble = 1'b0;
        setD(vecs[0].icode, 4'h0, vecs[0].rA, vecs[0].rB, 64'h88);
        setFwd(vecs[0].eD, vecs[0].mDM, vecs[0].mDE, vecs[0].wDM, vecs[0].wDE);
        @(posedge CLK);
        #3;
        RST = 1'b1;
        #1;
        chk("async reset E", 256'(getE()), 256'(nopRec));
        chk("async reset fwd_cnt", 256'(fwd_cnt), 256'(0));
        chk("async reset load_use", 256'(load_use), 256'(0));
        expFwd = 0;
        @(negedge CLK);
        RST = 1'b0;
        sbq.push_back('{e: '{icode: I_OPQ, ifun: 4'h0, valC: 64'h88, valA: EVALE, valB: WVALE,
                             dstE: 4'h3, dstM: 4'hF, srcA: 4'h2, srcB: 4'h3}, hits: 2});
        @(posedge CLK);
        #1;
        popCheck("post-reset opq");

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
